// File: rtl/jive_spi_master_pkg.sv
// Shared definitions for the jive_spi_master SPI peripheral: register
// offsets, CTRL/STAT bit positions and the shifter FSM state encoding.
package jive_spi_master_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;

  localparam int BIT_BUSY = 0;
  localparam int BIT_RXV  = 1;
  localparam int BIT_COL  = 2;
  localparam int BIT_SS   = 8;
  localparam int BIT_IE   = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } spi_state_e;

endpackage

// File: rtl/jive_spi_master_if.sv
// Peripheral bus of jive_spi_master (p0 request / p1 dtack protocol).
//   csel, rden, wren, addr[1:0], bena[3:0], wdata[31:0] : request, p0
//   rdata[31:0], dtack                                   : response, p1
// master: CPU side, slave: peripheral side.
interface jive_spi_master_if;
  logic        csel;
  logic        rden;
  logic        wren;
  logic [1:0]  addr;
  logic [3:0]  bena;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        dtack;

  modport master (output csel, rden, wren, addr, bena, wdata,
                  input  rdata, dtack);
  modport slave  (input  csel, rden, wren, addr, bena, wdata,
                  output rdata, dtack);
endinterface

// File: rtl/jive_spi_master_shifter.sv
// jive_spi_shifter: mode-0, MSB-first, 8-bit SPI shift engine.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start_i       begin a transfer of data_i (ignored unless idle)
//   data_i[7:0]   byte to transmit
//   miso_i        raw MISO pin (two-flop synchronised here)
//   busy_o        transfer in progress (SHIFT or DONE)
//   done_o        one-cycle pulse in DONE; rx_o is valid then
//   rx_o[7:0]     received byte
//   sclk_o, mosi_o  SPI pins
module jive_spi_shifter
  import jive_spi_master_pkg::*;
#(
  parameter int CLK_DIV = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] data_i,
  input  logic       miso_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] rx_o,
  output logic       sclk_o,
  output logic       mosi_o
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  spi_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] hcnt_q, hcnt_d;
  logic [7:0] sh_q, sh_d;
  logic       mosi_q, mosi_d;
  logic       sclk_q, sclk_d;
  logic       miso_s1_q, miso_s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      sh_q      <= '0;
      mosi_q    <= 1'b0;
      sclk_q    <= 1'b0;
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      sh_q      <= sh_d;
      mosi_q    <= mosi_d;
      sclk_q    <= sclk_d;
      miso_s1_q <= miso_i;
      miso_s2_q <= miso_s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    sh_d    = sh_q;
    mosi_d  = mosi_q;
    sclk_d  = sclk_q;
    done_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SHIFT;
          sh_d    = data_i;
          mosi_d  = data_i[7];
          cnt_d   = DIV_LAST;
          hcnt_d  = '0;
          sclk_d  = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == 8'd0) begin
          cnt_d  = DIV_LAST;
          sclk_d = ~sclk_q;
          hcnt_d = hcnt_q + 4'd1;
          if (!sclk_q) begin
            // Rising edge: TX bits move up, received bit enters the LSB;
            // MOSI keeps the current bit in its own flop until the fall.
            sh_d = {sh_q[6:0], miso_s2_q};
          end else if (hcnt_q == 4'd15) begin
            // Final falling edge: no next bit, MOSI simply holds.
            state_d = ST_DONE;
          end else begin
            mosi_d = sh_q[7];
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o = (state_q != ST_IDLE);
  assign rx_o   = sh_q;
  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;

endmodule

// File: rtl/jive_spi_master.sv
// jive_spi_master: memory-mapped SPI master (mode 0, MSB first, 8 bit).
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   bus              jive_spi_master_if.slave (p0 request, p1 dtack/rdata)
//   spi_ss_n         slave select, active low (= ~CTRL.SS)
//   spi_sclk         serial clock, idle low
//   spi_mosi         master out
//   spi_miso         master in (synchronised in the shifter)
//   spi_int          only with JIVE_SPI_IRQ_EN: level IRQ = IE & RXV
// Registers: off 0 DATA (wr starts transfer, rd returns rx byte and
// clears RXV), off 1 CTRL/STAT {IE[9], SS[8], COL[2], RXV[1], BUSY[0]}.
// Build option: define JIVE_SPI_IRQ_EN for the interrupt output and IE bit.
module jive_spi_master
  import jive_spi_master_pkg::*;
#(
  parameter int CLK_DIV = 6
) (
  input  logic clk,
  input  logic rst,
  jive_spi_master_if.slave bus,
  output logic spi_ss_n,
  output logic spi_sclk,
  output logic spi_mosi,
  input  logic spi_miso
`ifdef JIVE_SPI_IRQ_EN
  ,
  output logic spi_int
`endif
);

  logic        busy, done;
  logic [7:0]  sh_rx;
  logic        acc, wr_en, rd_en;
  logic        data_wr, data_rd, ctrl_wr0, ctrl_wr1, start;
  logic [31:0] stat, rdata_d, rdata_q;
  logic        dtack_q;
  logic [7:0]  rx_q;
  logic        rxv_q, col_q, ss_q;
  logic        ie_q, ie_d;

  // A combined read+write access behaves as a write.
  assign acc      = bus.csel & (bus.rden | bus.wren);
  assign wr_en    = bus.csel & bus.wren;
  assign rd_en    = bus.csel & bus.rden & ~bus.wren;
  assign data_wr  = wr_en & (bus.addr == ADDR_DATA) & bus.bena[0];
  assign data_rd  = rd_en & (bus.addr == ADDR_DATA);
  assign ctrl_wr0 = wr_en & (bus.addr == ADDR_CTRL) & bus.bena[0];
  assign ctrl_wr1 = wr_en & (bus.addr == ADDR_CTRL) & bus.bena[1];
  assign start    = data_wr & ~busy;

  jive_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .data_i  (bus.wdata[7:0]),
    .miso_i  (spi_miso),
    .busy_o  (busy),
    .done_o  (done),
    .rx_o    (sh_rx),
    .sclk_o  (spi_sclk),
    .mosi_o  (spi_mosi)
  );

  always_comb begin
    stat           = '0;
    stat[BIT_BUSY] = busy;
    stat[BIT_RXV]  = rxv_q;
    stat[BIT_COL]  = col_q;
    stat[BIT_SS]   = ss_q;
    stat[BIT_IE]   = ie_q;
  end

  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      case (bus.addr)
        ADDR_DATA: rdata_d = {24'h0, rx_q};
        ADDR_CTRL: rdata_d = stat;
        default:   rdata_d = '0;
      endcase
    end
  end

`ifdef JIVE_SPI_IRQ_EN
  logic int_q;

  always_comb begin
    ie_d = ie_q;
    if (ctrl_wr1) ie_d = bus.wdata[BIT_IE];
  end

  // Follows RXV one cycle late, but drops in p1 of a DATA read or IE clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) int_q <= 1'b0;
    else     int_q <= ie_d & rxv_q & ~data_rd;
  end

  assign spi_int = int_q;
`else
  assign ie_d = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      dtack_q <= 1'b0;
      rx_q    <= '0;
      rxv_q   <= 1'b0;
      col_q   <= 1'b0;
      ss_q    <= 1'b0;
      ie_q    <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      dtack_q <= acc;
      ie_q    <= ie_d;
      if (done) rx_q <= sh_rx;
      // Completion wins over a simultaneous DATA read.
      if (done)         rxv_q <= 1'b1;
      else if (data_rd) rxv_q <= 1'b0;
      if (data_wr && busy)                      col_q <= 1'b1;
      else if (ctrl_wr0 && bus.wdata[BIT_COL])  col_q <= 1'b0;
      if (ctrl_wr1) ss_q <= bus.wdata[BIT_SS];
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.dtack = dtack_q;
  assign spi_ss_n  = ~ss_q;

  logic unused_bits;
  assign unused_bits = ^{bus.wdata[31:10], bus.wdata[9], bus.bena[3:2]};

endmodule

// File: tb/tb_jive_spi_master.sv
module tb_jive_spi_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_ss_n, spi_sclk, spi_mosi, spi_miso;
  logic loop = 1'b1;
  logic miso_val = 1'b0;
`ifdef JIVE_SPI_IRQ_EN
  logic spi_int;
`endif
  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  logic [7:0] mon_bits;
  int mon_cnt = 0;
  int mon_cyc[16];

  jive_spi_master_if bif ();

  jive_spi_master #(.CLK_DIV(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bif.slave),
    .spi_ss_n (spi_ss_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
`ifdef JIVE_SPI_IRQ_EN
    ,
    .spi_int  (spi_int)
`endif
  );

  assign spi_miso = loop ? spi_mosi : miso_val;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge spi_sclk) begin
    if (mon_cnt < 16) mon_cyc[mon_cnt] = cyc;
    mon_bits = {mon_bits[6:0], spi_mosi};
    mon_cnt++;
  end

  // One bus access issued in the current cycle; returns p1 response.
  task automatic bus_access(input logic r, input logic w, input logic [1:0] a,
                            input logic [3:0] be, input logic [31:0] d,
                            output logic [31:0] rd, output logic ack);
    bif.csel = 1'b1; bif.rden = r; bif.wren = w;
    bif.addr = a; bif.bena = be; bif.wdata = d;
    @(posedge clk); #1;
    bif.csel = 1'b0; bif.rden = 1'b0; bif.wren = 1'b0;
    bif.addr = 2'd0; bif.bena = 4'h0; bif.wdata = 32'h0;
    rd = bif.rdata; ack = bif.dtack;
  endtask

  // Polls CTRL every cycle; k = index of the first poll that saw BUSY=0.
  task automatic wait_idle(output int k, output logic [31:0] st);
    logic ack;
    k = -1; st = '0;
    for (int i = 1; i <= 300; i++) begin
      bus_access(1'b1, 1'b0, 2'd1, 4'h1, 32'h0, st, ack);
      if (st[0] == 1'b0) begin k = i; break; end
    end
    tests_run++;
    if (k < 0) begin
      tests_failed++;
      $display("FAIL idle_timeout: busy still set after 300 polls");
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic ack;
    #3;
    tests_run++;
    if ({spi_ss_n, spi_sclk, spi_mosi, bif.dtack} !== 4'b1000 || bif.rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: ss_n/sclk/mosi/dtack=%b rdata=%h want 1000/0",
               {spi_ss_n, spi_sclk, spi_mosi, bif.dtack}, bif.rdata);
    end
    @(posedge clk); #1; rst = 1'b0;
    bus_access(1'b1, 1'b0, 2'd1, 4'hF, 32'h0, rd, ack);
    tests_run++;
    if (rd !== 32'h0 || ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ctrl_read: rdata=%h dtack=%b want 00000000/1", rd, ack);
    end
    @(posedge clk); #1;
    tests_run++;
    if (bif.dtack !== 1'b0 || bif.rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL dtack_single: dtack=%b rdata=%h want 0/0", bif.dtack, bif.rdata);
    end
  endtask

  task automatic test_loopback();
    logic [31:0] rd, st; logic ack; int k;
    loop = 1'b1;
    bus_access(1'b0, 1'b1, 2'd1, 4'h3, 32'h100, rd, ack);
    tests_run++;
    if (spi_ss_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL ss_p1: spi_ss_n=%b want 0", spi_ss_n);
    end
    mon_cnt = 0;
    bus_access(1'b0, 1'b1, 2'd0, 4'h1, 32'hA5, rd, ack);
    tests_run++;
    if (spi_mosi !== 1'b1) begin
      tests_failed++;
      $display("FAIL mosi_p1: mosi=%b want 1", spi_mosi);
    end
    wait_idle(k, st);
    tests_run++;
    if (k != 98) begin
      tests_failed++;
      $display("FAIL busy_fall: busy fell at cycle %0d want 98", k);
    end
    tests_run++;
    if (st !== 32'h102) begin
      tests_failed++;
      $display("FAIL stat_done: ctrl=%h want 00000102", st);
    end
    tests_run++;
    if (mon_cnt != 8 || mon_bits !== 8'hA5) begin
      tests_failed++;
      $display("FAIL mosi_bits: %0d edges bits=%h want 8/a5", mon_cnt, mon_bits);
    end
    bus_access(1'b1, 1'b0, 2'd0, 4'hF, 32'h0, rd, ack);
    tests_run++;
    if (rd !== 32'hA5) begin
      tests_failed++;
      $display("FAIL loop_rx: rdata=%h want 000000a5", rd);
    end
    bus_access(1'b1, 1'b0, 2'd1, 4'hF, 32'h0, rd, ack);
    tests_run++;
    if (rd !== 32'h100) begin
      tests_failed++;
      $display("FAIL rxv_clear: ctrl=%h want 00000100", rd);
    end
  endtask

  task automatic test_all_ones();
    logic [31:0] rd, st; logic ack; int k; logic bad;
    loop = 1'b0; miso_val = 1'b1; mon_cnt = 0;
    bus_access(1'b0, 1'b1, 2'd0, 4'h1, 32'h00, rd, ack);
    wait_idle(k, st);
    bus_access(1'b1, 1'b0, 2'd0, 4'hF, 32'h0, rd, ack);
    tests_run++;
    if (rd !== 32'hFF) begin
      tests_failed++;
      $display("FAIL ones_rx: rdata=%h want 000000ff", rd);
    end
    bad = (mon_cnt != 8);
    for (int i = 1; i < 8; i++) if (mon_cyc[i] - mon_cyc[i-1] != 12) bad = 1'b1;
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL sclk_edges: %0d rising edges, first gap %0d want 8 edges 12 apart",
               mon_cnt, mon_cyc[1] - mon_cyc[0]);
    end
    miso_val = 1'b0; loop = 1'b1;
  endtask

  task automatic test_collision();
    logic [31:0] rd, st; logic ack; int k;
    mon_cnt = 0;
    bus_access(1'b0, 1'b1, 2'd0, 4'h1, 32'h11, rd, ack);
    repeat (9) @(posedge clk); #1;
    bus_access(1'b0, 1'b1, 2'd0, 4'h1, 32'h22, rd, ack);
    wait_idle(k, st);
    tests_run++;
    if (st !== 32'h106) begin
      tests_failed++;
      $display("FAIL col_set: ctrl=%h want 00000106", st);
    end
    tests_run++;
    if (mon_bits !== 8'h11) begin
      tests_failed++;
      $display("FAIL col_tx: mosi byte=%h want 11", mon_bits);
    end
    bus_access(1'b1, 1'b0, 2'd0, 4'hF, 32'h0, rd, ack);
    tests_run++;
    if (rd !== 32'h11) begin
      tests_failed++;
      $display("FAIL col_rx: rdata=%h want 00000011", rd);
    end
    bus_access(1'b0, 1'b1, 2'd1, 4'h1, 32'h104, rd, ack);
    bus_access(1'b1, 1'b0, 2'd1, 4'hF, 32'h0, rd, ack);
    tests_run++;
    if (rd !== 32'h100) begin
      tests_failed++;
      $display("FAIL col_clear: ctrl=%h want 00000100", rd);
    end
  endtask

  task automatic test_done_race();
    logic [31:0] rd; logic ack;
    bus_access(1'b0, 1'b1, 2'd0, 4'h1, 32'h5A, rd, ack);
    repeat (96) @(posedge clk); #1;
    bus_access(1'b1, 1'b0, 2'd0, 4'hF, 32'h0, rd, ack);
    tests_run++;
    if (rd !== 32'h11) begin
      tests_failed++;
      $display("FAIL race_old: rdata=%h want 00000011", rd);
    end
    bus_access(1'b1, 1'b0, 2'd1, 4'hF, 32'h0, rd, ack);
    tests_run++;
    if (rd !== 32'h102) begin
      tests_failed++;
      $display("FAIL race_rxv: ctrl=%h want 00000102", rd);
    end
    bus_access(1'b1, 1'b0, 2'd0, 4'hF, 32'h0, rd, ack);
    tests_run++;
    if (rd !== 32'h5A) begin
      tests_failed++;
      $display("FAIL race_new: rdata=%h want 0000005a", rd);
    end
  endtask

  task automatic test_rw_both();
    logic [31:0] rd, st; logic ack; int k;
    bus_access(1'b1, 1'b1, 2'd0, 4'h1, 32'h3C, rd, ack);
    tests_run++;
    if (rd !== 32'h0 || ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL rw_ack: rdata=%h dtack=%b want 0/1", rd, ack);
    end
    wait_idle(k, st);
    bus_access(1'b1, 1'b0, 2'd0, 4'hF, 32'h0, rd, ack);
    tests_run++;
    if (rd !== 32'h3C) begin
      tests_failed++;
      $display("FAIL rw_rx: rdata=%h want 0000003c", rd);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd; logic ack;
    bus_access(1'b0, 1'b1, 2'd2, 4'hF, 32'hFFFF_FFFF, rd, ack);
    bus_access(1'b1, 1'b0, 2'd2, 4'hF, 32'h0, rd, ack);
    tests_run++;
    if (rd !== 32'h0 || ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL off2_read: rdata=%h dtack=%b want 0/1", rd, ack);
    end
    bus_access(1'b1, 1'b0, 2'd1, 4'hF, 32'h0, rd, ack);
    tests_run++;
    if (rd !== 32'h100) begin
      tests_failed++;
      $display("FAIL off2_ignored: ctrl=%h want 00000100", rd);
    end
  endtask

`ifdef JIVE_SPI_IRQ_EN
  task automatic test_irq();
    logic [31:0] rd, st; logic ack; int k;
    bus_access(1'b0, 1'b1, 2'd1, 4'h3, 32'h300, rd, ack);
    bus_access(1'b0, 1'b1, 2'd0, 4'h1, 32'h81, rd, ack);
    wait_idle(k, st);
    tests_run++;
    if (spi_int !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_rise: spi_int=%b want 1", spi_int);
    end
    bus_access(1'b1, 1'b0, 2'd0, 4'hF, 32'h0, rd, ack);
    tests_run++;
    if (spi_int !== 1'b0 || rd !== 32'h81) begin
      tests_failed++;
      $display("FAIL irq_clear: spi_int=%b rdata=%h want 0/00000081", spi_int, rd);
    end
    bus_access(1'b0, 1'b1, 2'd1, 4'h3, 32'h100, rd, ack);
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] rd; logic ack;
    bus_access(1'b0, 1'b1, 2'd0, 4'h1, 32'hFF, rd, ack);
    repeat (39) @(posedge clk); #1;
    tests_run++;
    if (spi_mosi !== 1'b1 || spi_ss_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL pre_reset: mosi=%b ss_n=%b want 1/0", spi_mosi, spi_ss_n);
    end
    rst = 1'b1; #1;
    tests_run++;
    if ({spi_ss_n, spi_sclk, spi_mosi} !== 3'b100) begin
      tests_failed++;
      $display("FAIL async_reset: ss_n/sclk/mosi=%b want 100", {spi_ss_n, spi_sclk, spi_mosi});
    end
    @(posedge clk); #1; rst = 1'b0;
    bus_access(1'b1, 1'b0, 2'd1, 4'hF, 32'h0, rd, ack);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL post_reset_ctrl: ctrl=%h want 00000000", rd);
    end
    bus_access(1'b1, 1'b0, 2'd0, 4'hF, 32'h0, rd, ack);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL post_reset_data: rdata=%h want 00000000", rd);
    end
  endtask

  initial begin
    bif.csel = 1'b0; bif.rden = 1'b0; bif.wren = 1'b0;
    bif.addr = 2'd0; bif.bena = 4'h0; bif.wdata = 32'h0;
    test_reset();
    test_loopback();
    test_all_ones();
    test_collision();
    test_done_race();
    test_rw_both();
    test_unmapped();
`ifdef JIVE_SPI_IRQ_EN
    test_irq();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
